// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions, reused by the TX path.
//   UART_DATA_W        data bits per frame
//   UART_CLKS_PER_BIT  default bit period in clock cycles (100 MHz / 115200)
//   uart_state_e       receiver FSM states (PARITY only reachable when the
//                      parity build option is enabled)
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 2**FIFO_ADDR_W entries.
// Ports:
//   Clk, Rst  clock, synchronous active-high reset (clears pointers)
//   push/din  write request and data; ignored when full unless popping
//   pop       read request; ignored when empty
//   dout      head entry (valid while !empty)
//   empty     pointers equal
//   full      pointers differ only in the MSB
module uart_sync_fifo #(
  parameter int FIFO_ADDR_W = 4,
  parameter int DATA_W      = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] MSB_ONLY = {1'b1, {FIFO_ADDR_W{1'b0}}};
  localparam logic [FIFO_ADDR_W:0] PTR_ONE  = (FIFO_ADDR_W+1)'(1);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [FIFO_ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic                 pop_ok, push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == MSB_ONLY);
  assign dout  = mem_q[rd_ptr_q[FIFO_ADDR_W-1:0]];

  // A pop frees the slot this same edge, so a full FIFO may still accept.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first, 1 stop bit) feeding a FWFT FIFO.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data and stop bits and the parity_err output.
// Ports:
//   Clk, Rst    clock, synchronous active-high reset
//   RX          asynchronous serial input, idles high
//   rd_en       pop FIFO head (ignored while data_valid=0)
//   Data_RX     FIFO head byte, valid while data_valid=1
//   data_valid  FIFO not empty
//   fifo_full   FIFO holds 2**FIFO_ADDR_W bytes
//   frame_err   1-cycle pulse, stop bit sampled 0
//   overflow    1-cycle pulse, good byte dropped on a full FIFO
//   parity_err  (option) 1-cycle pulse, parity mismatch with good stop bit
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   RX,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] Data_RX,
  output logic                   data_valid,
  output logic                   fifo_full,
  output logic                   frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   overflow
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e            state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic                   sample, push, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // A bit is sampled on the cycle the counter wraps.
  assign sample = (bit_cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = sample ? '0 : bit_cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      // After a framing error the line may be held low; wait for idle.
      WAIT_IDLE: if (rx_s_q) state_d = IDLE;
      IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      // Re-check the start bit half a period in; from here on every wrap
      // of bit_cnt lands mid-bit.
      START: begin
        if (bit_cnt_q == HALF_CNT) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[UART_DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data plus parity bit carries an even count of ones.
            if (^{shift_q, par_q}) parity_err_d = 1'b1;
            else                   push         = 1'b1;
`else
            push = 1'b1;
`endif
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // A full FIFO always has a valid head, so rd_en alone frees a slot.
  assign overflow_d = push && fifo_full && !rd_en;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= WAIT_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= RX;
      rx_s_q      <= rx_meta_q;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_sync_fifo #(
    .FIFO_ADDR_W (FIFO_ADDR_W),
    .DATA_W      (UART_DATA_W)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push),
    .din   (shift_q),
    .pop   (rd_en),
    .dout  (Data_RX),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign data_valid = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int C     = 16;
  localparam int HALF  = C / 2;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LAT_LIT = 172;
`else
  localparam int NBITS   = 10;
  localparam int LAT_LIT = 156;
`endif
  localparam int EV_PUSH = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RX  = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] Data_RX;
  logic       data_valid, fifo_full, frame_err, overflow;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_ADDR_W(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .RX         (RX),
    .rd_en      (rd_en),
    .Data_RX    (Data_RX),
    .data_valid (data_valid),
    .fifo_full  (fifo_full),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  int  cyc  = 0;
  int  nvec = 0;
  int  nerr = 0;
  bit  chk_en = 1'b0;

  // Model: a byte queue plus a list of frame outcomes due at known edges.
  byte unsigned mq[$];
  int           ev_edge[$];
  int           ev_kind[$];
  byte unsigned ev_byte[$];
  logic         exp_ferr = 1'b0, exp_ovf = 1'b0, exp_perr = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
    if (Rst) begin
      mq.delete(); ev_edge.delete(); ev_kind.delete(); ev_byte.delete();
      exp_ferr = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0;
    end else begin
      exp_ferr = 1'b0; exp_ovf = 1'b0; exp_perr = 1'b0;
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      for (int i = ev_edge.size() - 1; i >= 0; i--) begin
        if (ev_edge[i] == cyc) begin
          case (ev_kind[i])
            EV_PUSH: if (mq.size() == DEPTH) exp_ovf = 1'b1;
                     else mq.push_back(ev_byte[i]);
            EV_FERR: exp_ferr = 1'b1;
            default: exp_perr = 1'b1;
          endcase
          ev_edge.delete(i); ev_kind.delete(i); ev_byte.delete(i);
        end
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check("data_valid", data_valid, (mq.size() > 0));
      if (mq.size() > 0) check("Data_RX", Data_RX, mq[0]);
      check("fifo_full", fifo_full, (mq.size() == DEPTH));
      check("frame_err", frame_err, exp_ferr);
      check("overflow", overflow, exp_ovf);
`ifdef UART_RX_PARITY_EN
      check("parity_err", parity_err, exp_perr);
`endif
    end
  end

  // Frame outcome lands on edge n + 2 (sync) + 1 (idle detect) + HALF + 1
  // + (stop index)*C, where RX fell in cycle n. Leaves RX at the stop value.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    logic [NBITS-1:0] bits;
    int               n;
    int               kind;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^b) ^ par_flip, b, 1'b0};
    kind = !stop_bit ? EV_FERR : (par_flip ? EV_PERR : EV_PUSH);
`else
    bits = {stop_bit, b, 1'b0};
    kind = !stop_bit ? EV_FERR : EV_PUSH;
`endif
    @(posedge Clk); #1;
    n = cyc;
    ev_edge.push_back(n + 4 + HALF + (NBITS - 1) * C);
    ev_kind.push_back(kind);
    ev_byte.push_back(b);
    for (int j = 0; j < NBITS; j++) begin
      RX = bits[j];
      repeat (C) @(posedge Clk);
      #1;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic pop_one();
    @(posedge Clk); #1; rd_en = 1'b1;
    @(posedge Clk); #1; rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want $finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset
    @(posedge Clk); #1; chk_en = 1'b1;
    @(negedge Clk);
    check("rst_valid", data_valid, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    @(posedge Clk); #1; Rst = 1'b0;
    idle(5);

    // 1: 0xA5, exact latency to data_valid
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge Clk); #1; n = cyc;
        repeat (LAT_LIT - 1) @(posedge Clk);
        @(negedge Clk); check("t1_pre_valid", data_valid, 1'b0);
        @(negedge Clk); check("t1_valid", data_valid, 1'b1);
        check("t1_data", Data_RX, 8'hA5);
      end
    join
    idle(3);
    pop_one();
    @(negedge Clk); check("t1_popped", data_valid, 1'b0);

    // 2: short glitch, then 0x3C
    idle(2); RX = 1'b0; idle(4); RX = 1'b1; idle(30);
    send_frame(8'h3C, 1'b1);
    idle(4);
    @(negedge Clk); check("t2_data", Data_RX, 8'h3C);
    pop_one();

    // 3: bad stop bit, line held low, then 0x11
    send_frame(8'h3C, 1'b0);
    idle(40); RX = 1'b1; idle(5);
    send_frame(8'h11, 1'b1);
    idle(4);
    @(negedge Clk); check("t3_data", Data_RX, 8'h11);
    pop_one();
    @(negedge Clk); check("t3_only", data_valid, 1'b0);

    // 4: 17 bytes without reads
    for (int i = 0; i < 17; i++) send_frame(i[7:0], 1'b1);
    idle(4);
    @(negedge Clk); check("t4_full", fifo_full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); check("t4_order", Data_RX, i[7:0]);
      pop_one();
    end
    @(negedge Clk); check("t4_empty", data_valid, 1'b0);

    // 15 entries, then push and pop on the same edge
    for (int i = 0; i < 15; i++) send_frame(8'h20 + i[7:0], 1'b1);
    fork
      send_frame(8'h2F, 1'b1);
      begin
        @(posedge Clk); #1; n = cyc;
        repeat (LAT_LIT - 1) @(posedge Clk);
        #1; rd_en = 1'b1;
        @(posedge Clk); #1; rd_en = 1'b0;
      end
    join
    idle(2);
    @(negedge Clk); check("pp_full", fifo_full, 1'b0);
    for (int i = 1; i < 16; i++) begin
      @(negedge Clk); check("pp_order", Data_RX, 8'h20 + i[7:0]);
      pop_one();
    end
    @(negedge Clk); check("pp_empty", data_valid, 1'b0);

    // 5: reset mid data bit 3 (0xF8: line stays high from bit 3 on)
    send_frame(8'h99, 1'b1);
    idle(3);
    fork
      send_frame(8'hF8, 1'b1);
      begin
        @(posedge Clk); #1;
        repeat (4 * C + 8) @(posedge Clk);
        #1; Rst = 1'b1;
        @(posedge Clk); #1; Rst = 1'b0;
        @(negedge Clk);
        check("t5_valid", data_valid, 1'b0);
        check("t5_full", fifo_full, 1'b0);
        check("t5_ferr", frame_err, 1'b0);
        check("t5_ovf", overflow, 1'b0);
      end
    join
    idle(10);
    send_frame(8'h5A, 1'b1);
    idle(4);
    @(negedge Clk); check("t5_data", Data_RX, 8'h5A);
    pop_one();
    @(negedge Clk); check("t5_empty", data_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good, then parity wrong
    send_frame(8'h07, 1'b1);
    idle(4);
    @(negedge Clk); check("t6_data", Data_RX, 8'h07);
    pop_one();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(4);
    @(negedge Clk); check("t6_drop", data_valid, 1'b0);
`endif

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
